// File: rtl/fp_sqrt_pkg.sv
// Shared types and width/constant helpers for the sequential IEEE-754 square-root unit.
package fp_sqrt_pkg;

  typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

  typedef enum logic [2:0] {
    CLS_ZERO, CLS_SUB, CLS_NORM, CLS_INF, CLS_QNAN, CLS_SNAN
  } fp_class_t;

  localparam int MAX_W = 128;

  function automatic int fp_width(int exp_w, int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int fp_bias(int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
  function automatic logic [MAX_W-1:0] fp_qnan(int exp_w, int man_w);
    logic [MAX_W-1:0] q;
    q = '0;
    for (int i = 0; i <= exp_w; i++) q[man_w-1+i] = 1'b1;
    return q;
  endfunction

endpackage

// File: rtl/fp_sqrt_class.sv
// Combinational operand classifier: class, sign, special-case result and invalid flag.
module fp_sqrt_class
  import fp_sqrt_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] a,
  output fp_class_t            cls,
  output logic                 sign,
  output logic [EXP_W+MAN_W:0] special,
  output logic                 invalid
);

  localparam int W = fp_width(EXP_W, MAN_W);
  localparam logic [MAX_W-1:0] QNAN_WIDE = fp_qnan(EXP_W, MAN_W);
  localparam logic [W-1:0] QNAN = QNAN_WIDE[W-1:0];

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] frac;

  assign sign  = a[W-1];
  assign exp_f = a[W-2:MAN_W];
  assign frac  = a[MAN_W-1:0];

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    cls     = CLS_NORM;
    special = QNAN;
    invalid = sign;
    if (exp_f == '0) begin
      // Subnormals flush to a signed zero, exactly like true zeros.
      if (frac == '0) cls = CLS_ZERO;
      else            cls = CLS_SUB;
      special = {sign, {(W-1){1'b0}}};
      invalid = 1'b0;
    end else if (&exp_f) begin
      if (frac == '0) begin
        cls = CLS_INF;
        if (!sign) special = a;
      end else begin
        if (frac[MAN_W-1]) cls = CLS_QNAN;
        else               cls = CLS_SNAN;
        invalid = !frac[MAN_W-1];
      end
    end
  end

endmodule

// File: rtl/fp_sqrt_seq.sv
// Sequential IEEE-754 square root: restoring digit recurrence, one root bit per clock, RNE.
module fp_sqrt_seq
  import fp_sqrt_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [EXP_W+MAN_W:0] A,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [EXP_W+MAN_W:0] Out,
  output logic                 invalid
);

  localparam int W    = fp_width(EXP_W, MAN_W);
  localparam int N    = MAN_W + 2;        // root bits: leading 1, fraction, round bit
  localparam int RW   = 2 * N;
  localparam int REMW = N + 3;
  localparam int CW   = $clog2(N);
  localparam logic [EXP_W:0] BIAS_X = (EXP_W+1)'(fp_bias(EXP_W));

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [RW-1:0]   rad_q;
  logic [REMW-1:0] rem_q;
  logic [N-1:0]    root_q;
  logic [EXP_W-1:0] exp_q;

  fp_class_t   cls;
  logic        sign;
  logic [W-1:0] special;
  logic        cls_invalid;

  fp_sqrt_class #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_class (
    .a       (A),
    .cls     (cls),
    .sign    (sign),
    .special (special),
    .invalid (cls_invalid)
  );

  logic            accept, is_special;
  logic [EXP_W:0]  e_sum;
  logic [RW-1:0]   rad_init;
  logic [REMW-1:0] rem_t, sub;
  logic            take;
  logic [MAN_W:0]  rounded;
  logic            carry;
  logic [W-1:0]    result;

  assign accept     = (state_q == IDLE) && start;
  assign is_special = (cls != CLS_NORM) || sign;

  // E+bias has the parity of the unbiased exponent; odd means pre-shift the radicand.
  assign e_sum    = {1'b0, A[W-2:MAN_W]} + BIAS_X;
  assign rad_init = e_sum[0] ? {1'b1, A[MAN_W-1:0], {(MAN_W+3){1'b0}}}
                             : {2'b01, A[MAN_W-1:0], {(MAN_W+2){1'b0}}};

  assign rem_t = (rem_q << 2) | REMW'(rad_q[RW-1 -: 2]);
  assign sub   = REMW'({root_q, 2'b01});
  assign take  = rem_t >= sub;

  // Leading bit wraps to 0 only when rounding reaches 2.0; the fraction is then already 0.
  assign rounded = root_q[N-1:1] + (MAN_W+1)'(root_q[0]);
  assign carry   = ~rounded[MAN_W];
  assign result  = {1'b0, exp_q + EXP_W'(carry), rounded[MAN_W-1:0]};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = is_special ? DONE : CALC;
      CALC:  if (cnt_q == '0) state_d = ROUND;
      ROUND: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      Out     <= '0;
      invalid <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept && is_special) begin
        Out     <= special;
        invalid <= cls_invalid;
      end else if (state_q == ROUND) begin
        Out     <= result;
        invalid <= 1'b0;
      end
    end
  end

  // NOTE: recurrence registers are not reset; they are always loaded on acceptance before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      rad_q  <= rad_init;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= CW'(N - 1);
      exp_q  <= e_sum[EXP_W:1];
    end else if (state_q == CALC) begin
      rad_q  <= rad_q << 2;
      rem_q  <= take ? (rem_t - sub) : rem_t;
      root_q <= {root_q[N-2:0], take};
      cnt_q  <= cnt_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_sqrt_seq.sv
// Directed and randomised self-checking bench for fp_sqrt_seq with default single precision.
module tb_fp_sqrt_seq;

  localparam int LAT_NORM    = 26;  // edges after the accepting edge until done is seen
  localparam int LAT_SPECIAL = 0;   // specials show done right after the accepting edge
  localparam int LIMIT       = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] A;
  logic        ready, busy, done, invalid;
  logic [31:0] Out;

  int errors = 0;
  int checks = 0;

  fp_sqrt_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .A       (A),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .Out     (Out),
    .invalid (invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference for positive normals: floor sqrt by binary search, then round up when (q+1/2)^2 < M.
  function automatic logic [31:0] ref_sqrt(input logic [31:0] a);
    int     e, eo, re;
    longint m, big_m, lo, hi, mid, q;
    logic [31:0] r;
    e     = int'(a[30:23]) - 127;
    eo    = e & 1;
    m     = longint'({1'b1, a[22:0]});
    big_m = m << (23 + eo);
    lo    = 0;
    hi    = 64'd1 << 25;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= big_m) lo = mid;
      else                    hi = mid;
    end
    q = lo;
    if (4 * big_m > (2 * q + 1) * (2 * q + 1)) q = q + 1;
    re = (e - eo) / 2 + 127;
    if (q == (64'd1 << 24)) begin
      q  = 64'd1 << 23;
      re = re + 1;
    end
    r = {1'b0, re[7:0], q[22:0]};
    return r;
  endfunction

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] exp_out,
                        input logic exp_inv, input int exp_lat);
    int lat;
    bit busy_ok;
    @(negedge clk);
    check({tag, "_ready"}, ready, 1);
    check({tag, "_done_idle"}, done, 0);
    start = 1'b1;
    A     = a;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    A       = $urandom;
    lat     = 0;
    busy_ok = 1'b1;
    while (!done && lat < LIMIT) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!busy) busy_ok = 1'b0;
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_out"}, Out, exp_out);
    check({tag, "_invalid"}, invalid, exp_inv);
    check({tag, "_busy"}, busy_ok, 1);
  endtask

  initial begin
    int lat, ndone, first_lat;
    bit saw_done;
    logic [31:0] ra, e, f;

    reset = 1'b1;
    start = 1'b0;
    A     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out", Out, 0);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_invalid", invalid, 0);
    reset = 1'b0;

    run_op("one",    32'h3F800000, 32'h3F800000, 1'b0, LAT_NORM);
    run_op("four",   32'h40800000, 32'h40000000, 1'b0, LAT_NORM);
    run_op("two",    32'h40000000, 32'h3FB504F3, 1'b0, LAT_NORM);
    run_op("maxn",   32'h7F7FFFFF, 32'h5F7FFFFF, 1'b0, LAT_NORM);

    run_op("neg",    32'hBF800000, 32'h7FC00000, 1'b1, LAT_SPECIAL);
    run_op("nzero",  32'h80000000, 32'h80000000, 1'b0, LAT_SPECIAL);
    run_op("pinf",   32'h7F800000, 32'h7F800000, 1'b0, LAT_SPECIAL);
    run_op("subn",   32'h00000001, 32'h00000000, 1'b0, LAT_SPECIAL);
    run_op("snan",   32'h7F800001, 32'h7FC00000, 1'b1, LAT_SPECIAL);
    run_op("qnan",   32'hFFC00001, 32'h7FC00000, 1'b0, LAT_SPECIAL);
    run_op("ninf",   32'hFF800000, 32'h7FC00000, 1'b1, LAT_SPECIAL);

    // Start pulses while busy must be dropped, not queued.
    @(negedge clk);
    start = 1'b1;
    A     = 32'h40800000;
    @(posedge clk);
    @(negedge clk);
    lat       = 0;
    ndone     = 0;
    first_lat = -1;
    while (lat < 40) begin
      start = (lat == 5 || lat == 20);
      A     = start ? 32'h41800000 : $urandom;
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first_lat < 0) first_lat = lat;
      end
    end
    start = 1'b0;
    check("ign_pulses", ndone, 1);
    check("ign_latency", first_lat, LAT_NORM);
    check("ign_out", Out, 32'h40000000);
    run_op("sixteen", 32'h41800000, 32'h40800000, 1'b0, LAT_NORM);

    // Reset during CALC aborts without a done pulse.
    @(negedge clk);
    start = 1'b1;
    A     = 32'h40000000;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort_out", Out, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", ready, 1);
    check("abort_done", done, 0);
    check("abort_invalid", invalid, 0);
    saw_done = 1'b0;
    repeat (30) begin
      @(posedge clk);
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 0);
    run_op("after_abort", 32'h40000000, 32'h3FB504F3, 1'b0, LAT_NORM);

    // Back-to-back random positive normals: run_op issues start the cycle after done.
    for (int i = 0; i < 100; i++) begin
      e  = $urandom_range(1, 254);
      f  = $urandom & 32'h007FFFFF;
      ra = {1'b0, e[7:0], f[22:0]};
      run_op("rand", ra, ref_sqrt(ra), 1'b0, LAT_NORM);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
